// File: rtl/buffered_port.sv
// Buffered bidirectional channel: two independent DEPTH-word FIFOs
// between nodes A and B, with combinational and sticky panic reporting.

// One direction of the channel: a circular buffer with explicit pointer wrap.
module buffered_port_fifo #(
   parameter int N     = 8,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [N-1:0]  wdata,
   input  logic          pop,
   output logic [N-1:0]  rdata,
   output logic          full,
   output logic          avail,
   output logic [CW-1:0] count,
   output logic          err
);

   logic [N-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // Status and read port come only from registered count; no bypass.
   always_comb begin
      full    = (count_q == CW'(DEPTH));
      avail   = (count_q != '0);
      do_push = push & ~full;
      do_pop  = pop & avail;
      err     = (push & full) | (pop & ~avail);
      count   = count_q;
      rdata   = '0;
      if (do_pop) begin
         rdata = mem_q[rd_ptr_q];
      end
   end

   // Next pointers and count; an illegal op leaves its side untouched.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (reset) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            if (wr_ptr_q == PW'(DEPTH - 1)) begin
               wr_ptr_d = '0;
            end else begin
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
         end
         if (do_pop) begin
            if (rd_ptr_q == PW'(DEPTH - 1)) begin
               rd_ptr_d = '0;
            end else begin
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
   end

   // Storage; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// Top level: A->B and B->A FIFOs plus panic aggregation.
module buffered_port #(
   parameter int N     = 8,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   output logic          a_blocked,
   output logic          a_avail,
   input  logic          a_read,
   output logic [N-1:0]  a_in,
   input  logic          a_write,
   input  logic [N-1:0]  a_out,
   output logic          b_blocked,
   output logic          b_avail,
   input  logic          b_read,
   output logic [N-1:0]  b_in,
   input  logic          b_write,
   input  logic [N-1:0]  b_out,
   output logic [CW-1:0] ab_count,
   output logic [CW-1:0] ba_count,
   output logic          panic,
   output logic          panic_sticky
);

   logic ab_err, ba_err;
   logic sticky_q, sticky_d;

   buffered_port_fifo #(.N(N), .DEPTH(DEPTH)) u_ab (
      .clk   (clk),
      .reset (reset),
      .push  (a_write),
      .wdata (a_out),
      .pop   (b_read),
      .rdata (b_in),
      .full  (a_blocked),
      .avail (b_avail),
      .count (ab_count),
      .err   (ab_err)
   );

   buffered_port_fifo #(.N(N), .DEPTH(DEPTH)) u_ba (
      .clk   (clk),
      .reset (reset),
      .push  (b_write),
      .wdata (b_out),
      .pop   (a_read),
      .rdata (a_in),
      .full  (b_blocked),
      .avail (a_avail),
      .count (ba_count),
      .err   (ba_err)
   );

   // Panic is suppressed while reset discards the channel state.
   always_comb begin
      panic        = (ab_err | ba_err) & ~reset;
      sticky_d     = reset ? 1'b0 : (sticky_q | panic);
      panic_sticky = sticky_q;
   end

   // Sticky panic register.
   always_ff @(posedge clk) begin
      sticky_q <= sticky_d;
   end

endmodule

// File: tb/tb_buffered_port.sv
// Randomized scoreboard bench for buffered_port at DEPTH=4 and DEPTH=3,
// both instances driven by the same stimulus and checked against queue models.

module tb_buffered_port;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_read, a_write, b_read, b_write;
   logic [7:0] a_out, b_out;

   logic       a_blk4, a_av4, b_blk4, b_av4, pan4, st4;
   logic [7:0] a_in4, b_in4;
   logic [2:0] abc4, bac4;

   logic       a_blk3, a_av3, b_blk3, b_av3, pan3, st3;
   logic [7:0] a_in3, b_in3;
   logic [1:0] abc3, bac3;

   int n_cmp = 0;
   int n_fail = 0;

   // model: stream index 2*k = A->B, 2*k+1 = B->A, k=0 DEPTH 4, k=1 DEPTH 3
   byte unsigned mq [4][$];
   byte unsigned sb [4][$];
   bit  m_sticky [2];
   int  exp_abc [2];
   int  exp_bac [2];
   bit  exp_panic [2];
   bit  exp_sticky [2];
   bit  exp_ok = 1'b0;

   always #5 clk = ~clk;

   buffered_port #(.N(8), .DEPTH(4)) dut4 (
      .clk(clk), .reset(reset),
      .a_blocked(a_blk4), .a_avail(a_av4), .a_read(a_read),
      .a_in(a_in4), .a_write(a_write), .a_out(a_out),
      .b_blocked(b_blk4), .b_avail(b_av4), .b_read(b_read),
      .b_in(b_in4), .b_write(b_write), .b_out(b_out),
      .ab_count(abc4), .ba_count(bac4),
      .panic(pan4), .panic_sticky(st4)
   );

   buffered_port #(.N(8), .DEPTH(3)) dut3 (
      .clk(clk), .reset(reset),
      .a_blocked(a_blk3), .a_avail(a_av3), .a_read(a_read),
      .a_in(a_in3), .a_write(a_write), .a_out(a_out),
      .b_blocked(b_blk3), .b_avail(b_av3), .b_read(b_read),
      .b_in(b_in3), .b_write(b_write), .b_out(b_out),
      .ab_count(abc3), .ba_count(bac3),
      .panic(pan3), .panic_sticky(st3)
   );

   task automatic chk(input string nm, input int k, input int got,
                      input int exp);
      n_cmp++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s dut%0d at %0t: got %0h expected %0h",
                  nm, (k == 0) ? 4 : 3, $time, got, exp);
      end
   endtask

   // drive one cycle of inputs and advance the reference model
   task automatic step(input bit rst, input bit aw, input byte unsigned ao,
                       input bit ar, input bit bw, input byte unsigned bo,
                       input bit br, input bit chk_en);
      reset   = rst;
      a_write = aw;
      a_out   = ao;
      a_read  = ar;
      b_write = bw;
      b_out   = bo;
      b_read  = br;
      for (int k = 0; k < 2; k++) begin
         int d, ab, ba, sab, sba;
         bit p, pop_ab, pop_ba, push_ab, push_ba;
         d   = (k == 0) ? 4 : 3;
         ab  = 2 * k;
         ba  = 2 * k + 1;
         sab = mq[ab].size();
         sba = mq[ba].size();
         exp_abc[k]    = sab;
         exp_bac[k]    = sba;
         exp_sticky[k] = m_sticky[k];
         p = (aw && sab == d) || (bw && sba == d) ||
             (ar && sba == 0) || (br && sab == 0);
         if (rst) p = 1'b0;
         exp_panic[k] = p;
         pop_ab  = br && sab != 0;
         pop_ba  = ar && sba != 0;
         push_ab = aw && sab != d;
         push_ba = bw && sba != d;
         if (pop_ab) sb[ab].push_back(mq[ab][0]);
         if (pop_ba) sb[ba].push_back(mq[ba][0]);
         if (rst) begin
            mq[ab].delete();
            mq[ba].delete();
            m_sticky[k] = 1'b0;
         end else begin
            if (pop_ab) void'(mq[ab].pop_front());
            if (pop_ba) void'(mq[ba].pop_front());
            if (push_ab) mq[ab].push_back(ao);
            if (push_ba) mq[ba].push_back(bo);
            m_sticky[k] = m_sticky[k] | p;
         end
      end
      exp_ok = chk_en;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // monitor: compare status every cycle, pop scoreboard when a read is served
   always @(negedge clk) begin
      if (exp_ok) begin
         for (int k = 0; k < 2; k++) begin
            int d;
            bit bav, aav;
            logic [7:0] ain, bin;
            d = (k == 0) ? 4 : 3;
            bav = (k == 0) ? b_av4 : b_av3;
            aav = (k == 0) ? a_av4 : a_av3;
            ain = (k == 0) ? a_in4 : a_in3;
            bin = (k == 0) ? b_in4 : b_in3;
            chk("ab_count", k, (k == 0) ? int'(abc4) : int'(abc3), exp_abc[k]);
            chk("ba_count", k, (k == 0) ? int'(bac4) : int'(bac3), exp_bac[k]);
            chk("a_blocked", k, (k == 0) ? int'(a_blk4) : int'(a_blk3),
                int'(exp_abc[k] == d));
            chk("b_blocked", k, (k == 0) ? int'(b_blk4) : int'(b_blk3),
                int'(exp_bac[k] == d));
            chk("b_avail", k, int'(bav), int'(exp_abc[k] != 0));
            chk("a_avail", k, int'(aav), int'(exp_bac[k] != 0));
            chk("panic", k, (k == 0) ? int'(pan4) : int'(pan3),
                int'(exp_panic[k]));
            chk("panic_sticky", k, (k == 0) ? int'(st4) : int'(st3),
                int'(exp_sticky[k]));
            if (b_read && bav) begin
               if (sb[2 * k].size() == 0) chk("b_in_unexpected", k, int'(bin), -1);
               else chk("b_in", k, int'(bin), int'(sb[2 * k].pop_front()));
            end else begin
               chk("b_in_idle", k, int'(bin), 0);
            end
            if (a_read && aav) begin
               if (sb[2 * k + 1].size() == 0) chk("a_in_unexpected", k, int'(ain), -1);
               else chk("a_in", k, int'(ain), int'(sb[2 * k + 1].pop_front()));
            end else begin
               chk("a_in_idle", k, int'(ain), 0);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      a_write = 0; a_read = 0; b_write = 0; b_read = 0;
      a_out = 0; b_out = 0;
      @(posedge clk);
      #1;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      // 1: three words A->B, read out later
      step(0, 1, 8'h11, 0, 0, 0, 0, 1);
      step(0, 1, 8'h22, 0, 0, 0, 0, 1);
      step(0, 1, 8'h33, 0, 0, 0, 0, 1);
      idle(1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 1);
      // 2: fill, then overflow with 0x99, then drain originals
      for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h40 + i), 0, 0, 0, 0, 1);
      step(0, 1, 8'h99, 0, 0, 0, 0, 1);
      idle(1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 1);
      // 3: underflow on empty A->B
      step(0, 0, 0, 0, 0, 0, 1, 1);
      idle(1);
      // 4: full duplex streaming
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 8'hA0, 0, 1, 8'hB0, 0, 1);
      for (int i = 1; i < 9; i++)
         step(0, 1, 8'(8'hA0 + i), 1, 1, 8'(8'hB0 + i), 1, 1);
      step(0, 0, 0, 1, 0, 0, 1, 1);
      // 5: interleaved writes/reads so pointers wrap repeatedly
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 8'(8'hC0 + i), 0, 1, 8'(8'hD0 + i), 0, 1);
         step(0, 0, 0, 1, 0, 0, 1, 1);
      end
      // 6: reset mid-traffic with a write pending
      step(0, 1, 8'h61, 0, 0, 0, 0, 1);
      step(0, 1, 8'h62, 0, 0, 0, 0, 1);
      step(1, 1, 8'h63, 0, 0, 0, 0, 1);
      idle(2);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 99) < 55), 8'($urandom),
              ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 99) < 55), 8'($urandom),
              ($urandom_range(0, 99) < 45), 1);
      end
      idle(1);
      exp_ok = 1'b0;
      for (int s = 0; s < 4; s++) begin
         n_cmp++;
         if (sb[s].size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain stream %0d: got %0d left expected 0",
                     s, sb[s].size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
